op_route_dispatcher: RTL and testbench

- Registered, parametrised successor to the combinational op-word router of node 1.
- Accepts op words from the host link with a valid/ready handshake and decodes the ID field.
- Forwards each op to one of N_TASK task channels, N_PERIPH peripheral channels or the control (ESPIC) channel, each holding one entry with its own valid/ready handshake.
- Adds a timed soft-reset command, drop accounting for unmapped IDs, and per-channel back-pressure.

---
 rtl/op_route_pkg.sv | 49 ++++
 rtl/op_route_slot.sv | 52 +++++
 rtl/op_route_dispatcher.sv | 144 ++++++++++++++
 tb/tb_op_route_dispatcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/op_route_pkg.sv
`default_nettype none
// =============================================================================
// op_route_pkg : default op-word ID map and ID-to-channel decode helper
// Rev 1.0
// =============================================================================
package op_route_pkg;

   localparam int         OP_W_DEF        = 16;
   localparam int         ID_LSB_DEF      = 8;
   localparam int         ID_W_DEF        = 4;
   localparam int         N_TASK_DEF      = 6;
   localparam int         TASK_BASE_DEF   = 1;
   localparam int         N_PERIPH_DEF    = 5;
   localparam int         PERIPH_BASE_DEF = 10;
   localparam int         CTRL_ID_DEF     = 15;
   localparam logic [7:0] RST_CMD_DEF     = 8'h01;
   localparam int         CH_IDX_W        = 8;

   typedef struct packed {
      logic                mapped;
      logic [CH_IDX_W-1:0] idx;
   } chan_sel_t;

   // Slot 0 is ctrl, tasks follow from slot 1, peripherals follow the tasks.
   function automatic chan_sel_t id_to_channel(
      input int unsigned id,
      input int unsigned task_base,
      input int unsigned n_task,
      input int unsigned periph_base,
      input int unsigned n_periph,
      input int unsigned ctrl_id
   );
      chan_sel_t sel;
      sel.mapped = 1'b0;
      sel.idx    = '0;
      if (id == ctrl_id) begin
         sel.mapped = 1'b1;
      end else if (id >= task_base && id < task_base + n_task) begin
         sel.mapped = 1'b1;
         sel.idx    = CH_IDX_W'(1 + id - task_base);
      end else if (id >= periph_base && id < periph_base + n_periph) begin
         sel.mapped = 1'b1;
         sel.idx    = CH_IDX_W'(1 + n_task + id - periph_base);
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/op_route_slot.sv
`default_nettype none
// =============================================================================
// op_route_slot : single-entry valid/ready holding register for one channel
// Rev 1.0
// =============================================================================
module op_route_slot #(
   parameter int OP_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            wr_en,
   input  logic [OP_W-1:0] wr_op,
   input  logic            rd_ready,
   output logic [OP_W-1:0] op,
   output logic            valid
);

   logic [OP_W-1:0] op_d, op_q;
   logic            valid_d, valid_q;

   // Write wins over a same-cycle pop; clear wins over both. The word is kept on clear.
   always_comb begin
      op_d    = op_q;
      valid_d = valid_q;
      if (valid_q && rd_ready) begin
         valid_d = 1'b0;
      end
      if (wr_en) begin
         op_d    = wr_op;
         valid_d = 1'b1;
      end
      if (clr) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   assign op    = op_q;
   assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/op_route_dispatcher.sv
`default_nettype none
// =============================================================================
// op_route_dispatcher : registered op-word router with soft-reset and drop count
// Rev 1.0
// =============================================================================
module op_route_dispatcher
   import op_route_pkg::*;
#(
   parameter int          OP_W        = OP_W_DEF,
   parameter int          ID_LSB      = ID_LSB_DEF,
   parameter int          ID_W        = ID_W_DEF,
   parameter int          N_TASK      = N_TASK_DEF,
   parameter int          TASK_BASE   = TASK_BASE_DEF,
   parameter int          N_PERIPH    = N_PERIPH_DEF,
   parameter int          PERIPH_BASE = PERIPH_BASE_DEF,
   parameter int          CTRL_ID     = CTRL_ID_DEF,
   parameter logic [7:0]  RST_CMD     = RST_CMD_DEF,
   parameter int          RST_PULSE   = 4,
   parameter int          CNT_W       = 8,
   localparam int         NCH         = 1 + N_TASK + N_PERIPH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OP_W-1:0]     in_op,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [NCH*OP_W-1:0] ch_op,
   output logic [NCH-1:0]      ch_valid,
   input  logic [NCH-1:0]      ch_ready,
   output logic                soft_rst_n,
   output logic                drop_pulse,
   output logic [CNT_W-1:0]    drop_cnt
);

   localparam int         PCNT_W  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RST  = 1'b1;

   if ((TASK_BASE < 1) || (PERIPH_BASE < 1) ||
       (TASK_BASE + N_TASK > CTRL_ID) || (PERIPH_BASE + N_PERIPH > CTRL_ID) ||
       !((TASK_BASE + N_TASK <= PERIPH_BASE) || (PERIPH_BASE + N_PERIPH <= TASK_BASE)) ||
       (CTRL_ID >= (1 << ID_W)) || (ID_LSB + ID_W > OP_W) || (OP_W < 8) ||
       (RST_PULSE < 1)) begin : g_bad_id_map
      $error("op_route_dispatcher: illegal ID map or parameter set");
   end

   logic [0:0]        state_d, state_q;
   logic [PCNT_W-1:0] pcnt_d, pcnt_q;
   logic              drop_pulse_d, drop_pulse_q;
   logic [CNT_W-1:0]  drop_cnt_d, drop_cnt_q;

   logic [ID_W-1:0]   in_id;
   chan_sel_t         in_sel;
   logic [NCH-1:0]    hit;
   logic [NCH-1:0]    wr_en;
   logic              blocked;
   logic              is_rst_cmd;
   logic              fire;
   logic              slot_clr;
   logic              drop;

   assign in_id = in_op[ID_LSB +: ID_W];

   // Decode and acceptance; unmapped ops are never blocked by a channel.
   always_comb begin
      in_sel = id_to_channel(32'(in_id), TASK_BASE, N_TASK, PERIPH_BASE, N_PERIPH, CTRL_ID);
      hit    = '0;
      for (int k = 0; k < NCH; k++) begin
         hit[k] = in_sel.mapped && (int'(in_sel.idx) == k);
      end
      blocked    = |(hit & ch_valid & ~ch_ready);
      is_rst_cmd = hit[0] && (in_op[7:0] == RST_CMD);
      fire       = in_valid && in_ready;
      slot_clr   = fire && is_rst_cmd;
      drop       = fire && !in_sel.mapped;
      wr_en      = (fire && !is_rst_cmd) ? hit : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pcnt_q       <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         drop_pulse_q <= drop_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // pcnt counts down the remaining soft-reset cycles after the first.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (slot_clr) begin
               state_d = ST_RST;
               pcnt_d  = PCNT_W'(RST_PULSE - 1);
            end
         end
         ST_RST: begin
            if (pcnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               pcnt_d = pcnt_q - PCNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (state_q == ST_IDLE) && !blocked;
      soft_rst_n   = (state_q != ST_RST);
      drop_pulse_d = drop;
      drop_cnt_d   = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

   for (genvar k = 0; k < NCH; k++) begin : g_slot
      op_route_slot #(
         .OP_W(OP_W)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (slot_clr),
         .wr_en    (wr_en[k]),
         .wr_op    (in_op),
         .rd_ready (ch_ready[k]),
         .op       (ch_op[k*OP_W +: OP_W]),
         .valid    (ch_valid[k])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_op_route_dispatcher.sv
`default_nettype none
// =============================================================================
// tb_op_route_dispatcher : directed plus random stimulus against a channel model
// Rev 1.0
// =============================================================================
module tb_op_route_dispatcher;

   localparam int OP_W = 16;
   localparam int NCH  = 12;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [OP_W-1:0]     in_op;
   logic                in_valid;
   logic                in_ready;
   logic [NCH*OP_W-1:0] ch_op;
   logic [NCH-1:0]      ch_valid;
   logic [NCH-1:0]      ch_ready;
   logic                soft_rst_n;
   logic                drop_pulse;
   logic [7:0]          drop_cnt;

   logic                in_ready2;
   logic [NCH*OP_W-1:0] ch_op2;
   logic [NCH-1:0]      ch_valid2;
   logic                soft_rst_n2;
   logic                drop_pulse2;
   logic [1:0]          drop_cnt2;

   op_route_dispatcher u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_op      (in_op),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ch_op      (ch_op),
      .ch_valid   (ch_valid),
      .ch_ready   (ch_ready),
      .soft_rst_n (soft_rst_n),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt)
   );

   op_route_dispatcher #(.CNT_W(2)) u_dut_w2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_op      (in_op),
      .in_valid   (in_valid),
      .in_ready   (in_ready2),
      .ch_op      (ch_op2),
      .ch_valid   (ch_valid2),
      .ch_ready   (ch_ready),
      .soft_rst_n (soft_rst_n2),
      .drop_pulse (drop_pulse2),
      .drop_cnt   (drop_cnt2)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit              exp_valid [NCH];
   logic [OP_W-1:0] exp_word  [NCH];
   int              exp_drops;
   int              rst_left;
   bit              exp_pulse;
   bit              last_fire;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Channel slice for an op, -1 when unmapped (default ID map).
   function automatic int decode(input logic [OP_W-1:0] op);
      int id;
      id = int'(op[11:8]);
      if (id == 15) return 0;
      if (id >= 1 && id <= 6) return id;
      if (id >= 10 && id <= 14) return id - 3;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         exp_valid[k] = 1'b0;
         exp_word[k]  = '0;
      end
      exp_drops = 0;
      rst_left  = 0;
      exp_pulse = 1'b0;
   endtask

   task automatic compare_outputs();
      logic [NCH-1:0]      v;
      logic [NCH*OP_W-1:0] w;
      for (int k = 0; k < NCH; k++) begin
         v[k]              = exp_valid[k];
         w[k*OP_W +: OP_W] = exp_word[k];
      end
      check("ch_valid", ch_valid, v);
      check("ch_op", ch_op, w);
      check("soft_rst_n", soft_rst_n, rst_left == 0);
      check("drop_pulse", drop_pulse, exp_pulse);
      check("drop_cnt", drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
      check("drop_cnt_w2", drop_cnt2, (exp_drops > 3) ? 3 : exp_drops);
      check("ch_valid_w2", ch_valid2, v);
   endtask

   // One clock: drive, check in_ready mid-cycle, advance model, check outputs.
   task automatic step(input logic v, input logic [OP_W-1:0] op, input logic [NCH-1:0] rdy);
      int k;
      bit exp_rdy;
      bit fire;
      in_valid = v;
      in_op    = op;
      ch_ready = rdy;
      @(negedge clk);
      k       = decode(op);
      exp_rdy = (rst_left == 0) && ((k < 0) || !exp_valid[k] || rdy[k]);
      check("in_ready", in_ready, exp_rdy);
      fire      = v && exp_rdy;
      last_fire = fire;
      exp_pulse = 1'b0;
      if (rst_left > 0) begin
         rst_left--;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (exp_valid[c] && rdy[c]) exp_valid[c] = 1'b0;
         end
         if (fire) begin
            if (k < 0) begin
               exp_drops++;
               exp_pulse = 1'b1;
            end else if (k == 0 && op[7:0] == 8'h01) begin
               for (int c = 0; c < NCH; c++) exp_valid[c] = 1'b0;
               rst_left = 4;
            end else begin
               exp_valid[k] = 1'b1;
               exp_word[k]  = op;
            end
         end
      end
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      last_fire = 1'b1;
   endtask

   function automatic logic [OP_W-1:0] rand_op();
      logic [3:0] id;
      logic [3:0] hi;
      logic [7:0] lo;
      id = 4'($urandom_range(0, 15));
      hi = 4'($urandom_range(0, 15));
      lo = 8'($urandom_range(0, 255));
      if (id == 4'd15 && $urandom_range(0, 1) == 0) lo = 8'h01;
      return {hi, id, lo};
   endfunction

   localparam logic [NCH-1:0] ALL1  = '1;
   localparam logic [NCH-1:0] NONE  = '0;
   localparam logic [NCH-1:0] NO_P0 = ~(12'b1 << 7);

   initial begin
      logic [OP_W-1:0] rop;
      logic            rv;
      logic [NCH-1:0]  rr;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      ch_ready  = '0;
      last_fire = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_outputs();
      rst_n = 1'b1;

      step(1'b1, 16'h0234, ALL1);
      step(1'b0, 16'h0000, ALL1);

      step(1'b1, 16'h0A55, NO_P0);
      step(1'b1, 16'h0A66, NO_P0);
      step(1'b1, 16'h0A66, NO_P0);
      step(1'b1, 16'h0A66, ALL1);
      step(1'b0, 16'h0000, ALL1);

      step(1'b1, 16'h0000, ALL1);
      step(1'b1, 16'h0700, ALL1);
      step(1'b1, 16'h0912, ALL1);
      step(1'b1, 16'h0000, ALL1);
      step(1'b1, 16'h0800, ALL1);
      step(1'b0, 16'h0000, ALL1);

      step(1'b1, 16'h0100, NONE);
      step(1'b1, 16'h0B00, NONE);
      step(1'b1, 16'h0F01, NONE);
      for (int i = 0; i < 5; i++) step(1'b1, 16'h0F02, NONE);
      step(1'b0, 16'h0000, NONE);
      step(1'b0, 16'h0000, ALL1);

      for (int i = 1; i <= 6; i++) step(1'b1, 16'(i << 8), ALL1);
      step(1'b0, 16'h0000, ALL1);

      step(1'b1, 16'h0F01, ALL1);
      step(1'b0, 16'h0000, ALL1);
      async_reset();
      step(1'b1, 16'h0F03, ALL1);
      step(1'b0, 16'h0000, ALL1);

      rop = '0;
      rv  = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!(rv && !last_fire)) begin
            rv  = ($urandom_range(0, 9) < 7);
            rop = rand_op();
         end
         for (int b = 0; b < NCH; b++) rr[b] = ($urandom_range(0, 3) != 0);
         if (n == 1500) begin
            async_reset();
            rv = 1'b0;
         end
         step(rv, rop, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
